// File: rtl/fetch_stage_dual_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_stage_dual_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // One fetched instruction together with the address it was read from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Decode can take at most two per cycle; a request of 3 is treated as 2.
  function automatic logic [1:0] sat_deq(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-in / two-out circular fetch queue with zero-latency head read and flush.
module fetch_queue
  import fetch_stage_dual_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  fetch_entry_t              push0_i,
  input  fetch_entry_t              push1_i,
  input  logic [1:0]                deq_cnt_i,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic                      valid0_o,
  output logic                      valid1_o,
  output fetch_entry_t              head0_o,
  output fetch_entry_t              head1_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];

  logic [CW-1:0] req_deq;
  logic [CW-1:0] eff_deq;
  logic [CW-1:0] push_cnt;

  // Clamp the dequeue request to what the queue actually holds.
  always_comb begin
    req_deq  = CW'(sat_deq(deq_cnt_i));
    eff_deq  = (req_deq > count_q) ? count_q : req_deq;
    push_cnt = push ? CW'(2) : '0;
  end

  // Pointer, occupancy and storage next-state; flush empties the queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Dequeue and push coexist: the push lands at the tail while the
      // head advances, so order is preserved without any special case.
      head_d  = head_q + PW'(eff_deq);
      count_d = count_q - eff_deq + push_cnt;
      if (push) begin
        mem_d[tail_q]          = push0_i;
        mem_d[tail_q + PW'(1)] = push1_i;
        tail_d                 = tail_q + PW'(2);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head and head+1 are read straight from storage.
  always_comb begin
    head0_o  = mem_q[head_q];
    head1_o  = mem_q[head_q + PW'(1)];
    valid0_o = (count_q != '0);
    valid1_o = (count_q >= CW'(2));
    count_o  = count_q;
  end

endmodule

// File: rtl/fetch_stage_dual.sv
// Dual-wide instruction fetch: PC register, fetch/redirect control, fetch queue.
module fetch_stage_dual
  import fetch_stage_dual_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr0_o,
  output logic [31:0] addr1_o,
  input  logic [31:0] instr0_i,
  input  logic [31:0] instr1_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [1:0]  deq_cnt_i,
  output logic        valid0_o,
  output logic        valid1_o,
  output logic [31:0] instr0_o,
  output logic [31:0] instr1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FIRE_MAX = CW'(QDEPTH - 2);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic          fire;
  logic          flush;
  fetch_entry_t  push0, push1;
  fetch_entry_t  head0, head1;

  // Fetch only when two free slots are guaranteed before any dequeue.
  always_comb begin
    flush = redirect_i;
    fire  = !rst && !redirect_i && (count <= FIRE_MAX);
  end

  // Next PC: redirect beats fetch; pc wraps naturally at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {target_i[31:2], 2'b00};
    end else if (fire) begin
      pc_d = pc_q + 32'd8;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fetch addresses and the pair of entries offered to the queue.
  always_comb begin
    addr0_o     = pc_q;
    addr1_o     = pc_q + 32'd4;
    push0.pc    = pc_q;
    push0.instr = instr0_i;
    push1.pc    = pc_q + 32'd4;
    push1.instr = instr1_i;
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fire),
    .push0_i   (push0),
    .push1_i   (push1),
    .deq_cnt_i (deq_cnt_i),
    .count_o   (count),
    .valid0_o  (valid0_o),
    .valid1_o  (valid1_o),
    .head0_o   (head0),
    .head1_o   (head1)
  );

  // Unpack queue head entries onto the decode-facing ports.
  always_comb begin
    instr0_o = head0.instr;
    instr1_o = head1.instr;
    pc0_o    = head0.pc;
    pc1_o    = head1.pc;
  end

endmodule

// File: tb/tb_fetch_stage_dual.sv
// Self-checking bench for fetch_stage_dual: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fetch_stage_dual;

  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr0_o, addr1_o;
  logic [31:0] instr0_i, instr1_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [1:0]  deq_cnt_i;
  logic        valid0_o, valid1_o;
  logic [31:0] instr0_o, instr1_o, pc0_o, pc1_o;

  always #5 clk = ~clk;

  fetch_stage_dual #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr0_o    (addr0_o),
    .addr1_o    (addr1_o),
    .instr0_i   (instr0_i),
    .instr1_i   (instr1_i),
    .redirect_i (redirect_i),
    .target_i   (target_i),
    .deq_cnt_i  (deq_cnt_i),
    .valid0_o   (valid0_o),
    .valid1_o   (valid1_o),
    .instr0_o   (instr0_o),
    .instr1_o   (instr1_o),
    .pc0_o      (pc0_o),
    .pc1_o      (pc1_o)
  );

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign instr0_i = imem(addr0_o);
  assign instr1_i = imem(addr1_o);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0] m_pc;
  ent_t        mq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_edge();
    int unsigned n;
    bit          fire;
    if (rst) begin
      m_pc = RESET_PC;
      mq.delete();
    end else if (redirect_i) begin
      m_pc = {target_i[31:2], 2'b00};
      mq.delete();
    end else begin
      fire = (mq.size() <= QDEPTH - 2);
      n = (deq_cnt_i == 2'd3) ? 2 : deq_cnt_i;
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (fire) begin
        mq.push_back('{pc: m_pc, instr: imem(m_pc)});
        mq.push_back('{pc: m_pc + 32'd4, instr: imem(m_pc + 32'd4)});
        m_pc = m_pc + 32'd8;
      end
    end
  endtask

  // Compare every observable output with the model.
  task automatic compare();
    chk("addr0", addr0_o, m_pc);
    chk("addr1", addr1_o, m_pc + 32'd4);
    chk("valid0", {31'd0, valid0_o}, {31'd0, mq.size() >= 1});
    chk("valid1", {31'd0, valid1_o}, {31'd0, mq.size() >= 2});
    if (mq.size() >= 1) begin
      chk("pc0", pc0_o, mq[0].pc);
      chk("instr0", instr0_o, mq[0].instr);
    end
    if (mq.size() >= 2) begin
      chk("pc1", pc1_o, mq[1].pc);
      chk("instr1", instr1_o, mq[1].instr);
    end
  endtask

  task automatic cycle(input logic r, input logic rd, input logic [31:0] t, input logic [1:0] d);
    rst        = r;
    redirect_i = rd;
    target_i   = t;
    deq_cnt_i  = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic        r, rd;
    logic [31:0] t;
    logic [1:0]  d;

    // Reset; first fetch addresses come from RESET_PC.
    cycle(1'b1, 1'b0, 32'h0, 2'd0);
    cycle(1'b1, 1'b0, 32'h0, 2'd0);
    chk("rst_addr0", addr0_o, 32'hBFC0_0000);
    chk("rst_addr1", addr1_o, 32'hBFC0_0004);
    chk("rst_valid0", {31'd0, valid0_o}, 32'd0);

    // Two fires fill the queue, then fetch stalls.
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    chk("fill1_pc0", pc0_o, 32'hBFC0_0000);
    chk("fill1_pc1", pc1_o, 32'hBFC0_0004);
    chk("fill1_addr0", addr0_o, 32'hBFC0_0008);
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    chk("fill2_addr0", addr0_o, 32'hBFC0_0010);
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    chk("stall_addr0", addr0_o, 32'hBFC0_0010);

    // 4 -> 3 -> 2 with no fire, then fire with dequeue (2+2-1), wrapping pointers.
    cycle(1'b0, 1'b0, 32'h0, 2'd1);
    cycle(1'b0, 1'b0, 32'h0, 2'd1);
    cycle(1'b0, 1'b0, 32'h0, 2'd1);
    chk("wrap_pc0", pc0_o, 32'hBFC0_000C);
    chk("wrap_addr0", addr0_o, 32'hBFC0_0018);

    // Back to a full queue, then redirect to an unaligned target.
    cycle(1'b0, 1'b0, 32'h0, 2'd1);
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    cycle(1'b0, 1'b1, 32'hBFC0_0103, 2'd2);
    chk("redir_valid0", {31'd0, valid0_o}, 32'd0);
    chk("redir_addr0", addr0_o, 32'hBFC0_0100);
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    chk("redir_pc0", pc0_o, 32'hBFC0_0100);
    chk("redir_pc1", pc1_o, 32'hBFC0_0104);

    // Reach count=1 and over-request a dequeue alongside a fire.
    cycle(1'b0, 1'b0, 32'h0, 2'd1);
    cycle(1'b0, 1'b0, 32'h0, 2'd2);
    chk("cnt1_pc0", pc0_o, 32'hBFC0_010C);
    chk("cnt1_valid1", {31'd0, valid1_o}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 2'd2);
    chk("under_pc0", pc0_o, 32'hBFC0_0110);
    chk("under_pc1", pc1_o, 32'hBFC0_0114);

    // Reset dominates a simultaneous redirect.
    cycle(1'b1, 1'b1, 32'h0000_1000, 2'd0);
    chk("rstred_addr0", addr0_o, 32'hBFC0_0000);
    chk("rstred_valid0", {31'd0, valid0_o}, 32'd0);

    // PC wrap past the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 2'd0);
    chk("wrapredir_addr1", addr1_o, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 2'd0);
    chk("pcwrap_addr0", addr0_o, 32'h0000_0000);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 2'd0);
    chk("addr1_wrap", addr1_o, 32'h0000_0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 99) < 6);
      t  = $urandom;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      d  = 2'($urandom_range(0, 3));
      cycle(r, rd, t, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
